// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared types and default sizes for the scoreboarded regfile.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_DEPTH  = 16;

    typedef enum logic [0:0] {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_e;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb_if
//  Description : Write, issue and dual read port bundle of the regfile.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_sb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_addr;
    logic [ADDR_W-1:0] r_addr1;
    logic [ADDR_W-1:0] r_addr2;
    logic [DATA_W-1:0] r_data1;
    logic [DATA_W-1:0] r_data2;
    logic              busy1;
    logic              busy2;
    logic              init_done;

    modport master (
        output we, w_addr, w_data, iss_valid, iss_addr, r_addr1, r_addr2,
        input  r_data1, r_data2, busy1, busy2, init_done
    );

    modport slave (
        input  we, w_addr, w_data, iss_valid, iss_addr, r_addr1, r_addr2,
        output r_data1, r_data2, busy1, busy2, init_done
    );
endinterface : regfile_sb_if
`default_nettype wire

// File: rtl/regfile_sb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : rf_scoreboard
//  Description : Per-register pending bits with issue/write/sweep update.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  wire logic              clk,
    input  wire logic              clr_en_i,
    input  wire logic [ADDR_W-1:0] clr_addr_i,
    input  wire logic              wr_en_i,
    input  wire logic [ADDR_W-1:0] wr_addr_i,
    input  wire logic              set_en_i,
    input  wire logic [ADDR_W-1:0] set_addr_i,
    input  wire logic [ADDR_W-1:0] lk_addr1_i,
    input  wire logic [ADDR_W-1:0] lk_addr2_i,
    output logic                   busy1_o,
    output logic                   busy2_o
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Issue has priority so a same-cycle issue+write leaves the bit pending.
    for (genvar i = 0; i < DEPTH; i++) begin : g_bit
        assign busy_d[i] = (set_en_i && set_addr_i == ADDR_W'(i)) ? 1'b1 :
                           ((wr_en_i  && wr_addr_i  == ADDR_W'(i)) ||
                            (clr_en_i && clr_addr_i == ADDR_W'(i))) ? 1'b0 :
                           busy_q[i];
    end

    always_ff @(posedge clk) begin
        busy_q <= busy_d;
    end

    assign busy1_o = (ZERO_REG != 0 && lk_addr1_i == '0) ? 1'b0 : busy_q[lk_addr1_i];
    assign busy2_o = (ZERO_REG != 0 && lk_addr2_i == '0) ? 1'b0 : busy_q[lk_addr2_i];

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb
//  Description : Register file with clear sweep, forwarding and scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    regfile_sb_if.slave bus
);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              init_done_q;
    logic              clr_en;
    logic              run;
    logic              we_eff;
    logic              iss_eff;
    logic              sb_busy1, sb_busy2;
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RF_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= (state_d == RF_RUN);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_en  = 1'b0;
        case (state_q)
            RF_INIT: begin
                clr_en = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RF_RUN;
                    cnt_d   = '0;
                end
            end
            RF_RUN:  ;
            default: state_d = RF_INIT;
        endcase
    end

    assign run     = (state_q == RF_RUN);
    assign we_eff  = run && bus.we        && !(ZERO_REG != 0 && bus.w_addr   == '0);
    assign iss_eff = run && bus.iss_valid && !(ZERO_REG != 0 && bus.iss_addr == '0);

    // The sweep and normal writes are mutually exclusive by state.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem_q[cnt_q] <= '0;
        end else if (we_eff) begin
            mem_q[bus.w_addr] <= bus.w_data;
        end
    end

    function automatic logic [DATA_W-1:0] rd_port(
        input logic [ADDR_W-1:0] a,
        input logic              fwd_en,
        input logic [ADDR_W-1:0] fwd_addr,
        input logic [DATA_W-1:0] fwd_data,
        input logic [DATA_W-1:0] stored
    );
        if (ZERO_REG != 0 && a == '0)
            return '0;
        else if (BYPASS != 0 && fwd_en && fwd_addr == a)
            return fwd_data;
        else
            return stored;
    endfunction

    assign bus.r_data1 = run ? rd_port(bus.r_addr1, we_eff, bus.w_addr, bus.w_data,
                                       mem_q[bus.r_addr1]) : '0;
    assign bus.r_data2 = run ? rd_port(bus.r_addr2, we_eff, bus.w_addr, bus.w_data,
                                       mem_q[bus.r_addr2]) : '0;

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .clr_en_i   (clr_en),
        .clr_addr_i (cnt_q),
        .wr_en_i    (we_eff),
        .wr_addr_i  (bus.w_addr),
        .set_en_i   (iss_eff),
        .set_addr_i (bus.iss_addr),
        .lk_addr1_i (bus.r_addr1),
        .lk_addr2_i (bus.r_addr2),
        .busy1_o    (sb_busy1),
        .busy2_o    (sb_busy2)
    );

    assign bus.busy1     = run && sb_busy1;
    assign bus.busy2     = run && sb_busy2;
    assign bus.init_done = init_done_q;

endmodule : regfile_sb
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_sb
//  Description : Directed self-checking bench, forwarding and non-forwarding DUTs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    logic clk;
    logic rst;

    regfile_sb_if #(.DATA_W(16), .ADDR_W(4)) bus ();
    regfile_sb_if #(.DATA_W(16), .ADDR_W(4)) bus_nb ();

    assign bus_nb.we        = bus.we;
    assign bus_nb.w_addr    = bus.w_addr;
    assign bus_nb.w_data    = bus.w_data;
    assign bus_nb.iss_valid = bus.iss_valid;
    assign bus_nb.iss_addr  = bus.iss_addr;
    assign bus_nb.r_addr1   = bus.r_addr1;
    assign bus_nb.r_addr2   = bus.r_addr2;

    regfile_sb #(.DATA_W(16), .DEPTH(16), .ADDR_W(4), .BYPASS(1), .ZERO_REG(1))
        u_dut (.clk(clk), .rst(rst), .bus(bus));

    regfile_sb #(.DATA_W(16), .DEPTH(16), .ADDR_W(4), .BYPASS(0), .ZERO_REG(1))
        u_dut_nb (.clk(clk), .rst(rst), .bus(bus_nb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL queue_empty observed=%0h expected=<none>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic ce(input string tag, input logic [31:0] obs, input logic [31:0] v);
        expect_val(tag, v);
        check(obs);
    endtask

    // Counts negedges seen with init_done low; write/issue strobes are dropped
    // after ten cycles so they span a good part of the sweep.
    task automatic wait_init(input string tag);
        int n;
        n = 0;
        expect_val(tag, 32'd16);
        #1;
        while (bus.init_done !== 1'b1 && n < 40) begin
            n++;
            if (n == 10) begin
                bus.we        = 1'b0;
                bus.iss_valid = 1'b0;
            end
            @(negedge clk);
            #1;
        end
        bus.we        = 1'b0;
        bus.iss_valid = 1'b0;
        check(n);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.we        = 1'b0;
        bus.w_addr    = '0;
        bus.w_data    = '0;
        bus.iss_valid = 1'b0;
        bus.iss_addr  = '0;
        bus.r_addr1   = 4'd5;
        bus.r_addr2   = 4'd7;

        // Reset held: INIT, outputs forced low
        repeat (2) @(negedge clk);
        #1;
        ce("rst_init_done", bus.init_done, 0);
        ce("rst_rdata1",    bus.r_data1,   0);
        ce("rst_busy2",     bus.busy2,     0);

        // Full clear sequence after a single reset edge
        @(negedge clk);
        rst = 1'b0;
        wait_init("init_len");
        ce("init_done_nb", bus_nb.init_done, 1);
        for (int a = 0; a < 16; a++) begin
            bus.r_addr1 = 4'(a);
            bus.r_addr2 = 4'(15 - a);
            #1;
            ce("init_zero_r1", bus.r_data1, 0);
            ce("init_zero_r2", bus.r_data2, 0);
            ce("init_busy1",   bus.busy1,   0);
        end

        // Write/read and same-cycle forwarding
        @(negedge clk);
        bus.we = 1'b1; bus.w_addr = 4'd5; bus.w_data = 16'hBEEF;
        bus.r_addr1 = 4'd5; bus.r_addr2 = 4'd6;
        #1;
        ce("fwd_beef",      bus.r_data1,    16'hBEEF);
        ce("nofwd_old",     bus_nb.r_data1, 16'h0000);
        ce("fwd_other",     bus.r_data2,    16'h0000);
        @(negedge clk);
        bus.we = 1'b0;
        #1;
        ce("rd_beef",       bus.r_data1,    16'hBEEF);
        ce("rd_beef_nb",    bus_nb.r_data1, 16'hBEEF);
        @(negedge clk);
        bus.we = 1'b1; bus.w_data = 16'h1234;
        #1;
        ce("fwd_1234",      bus.r_data1,    16'h1234);
        ce("nofwd_beef",    bus_nb.r_data1, 16'hBEEF);
        @(negedge clk);
        bus.we = 1'b0;
        #1;
        ce("rd_1234",       bus.r_data1,    16'h1234);
        ce("rd_1234_nb",    bus_nb.r_data1, 16'h1234);

        // Scoreboard set/clear and issue-wins
        @(negedge clk);
        bus.iss_valid = 1'b1; bus.iss_addr = 4'd7;
        bus.r_addr1 = 4'd7; bus.r_addr2 = 4'd12;
        #1;
        ce("busy_no_bypass", bus.busy1, 0);
        @(negedge clk);
        bus.iss_addr = 4'd12;
        #1;
        ce("busy7_set",     bus.busy1, 1);
        ce("busy12_pre",    bus.busy2, 0);
        @(negedge clk);
        bus.iss_valid = 1'b0;
        bus.we = 1'b1; bus.w_addr = 4'd7; bus.w_data = 16'h0042;
        #1;
        ce("busy7_hold",    bus.busy1,      1);
        ce("busy12_set",    bus.busy2,      1);
        ce("fwd_0042",      bus.r_data1,    16'h0042);
        ce("nofwd_0042",    bus_nb.r_data1, 16'h0000);
        @(negedge clk);
        bus.we = 1'b0;
        #1;
        ce("busy7_clr",     bus.busy1,   0);
        ce("rd_0042",       bus.r_data1, 16'h0042);
        @(negedge clk);
        bus.iss_valid = 1'b1; bus.iss_addr = 4'd7;
        bus.we = 1'b1; bus.w_addr = 4'd7; bus.w_data = 16'h0055;
        @(negedge clk);
        bus.iss_valid = 1'b0; bus.we = 1'b0;
        #1;
        ce("iss_wins",      bus.busy1,   1);
        ce("iss_wr_data",   bus.r_data1, 16'h0055);

        // Write to a register that is not pending
        @(negedge clk);
        bus.we = 1'b1; bus.w_addr = 4'd9; bus.w_data = 16'h0909; bus.r_addr2 = 4'd9;
        @(negedge clk);
        bus.we = 1'b0;
        #1;
        ce("idle_wr_busy",  bus.busy2,   0);
        ce("idle_wr_data",  bus.r_data2, 16'h0909);

        // Register zero
        @(negedge clk);
        bus.we = 1'b1; bus.w_addr = 4'd0; bus.w_data = 16'hFFFF;
        bus.iss_valid = 1'b1; bus.iss_addr = 4'd0;
        bus.r_addr1 = 4'd0; bus.r_addr2 = 4'd0;
        #1;
        ce("zero_no_fwd",   bus.r_data1,    0);
        ce("zero_no_fwd_nb",bus_nb.r_data1, 0);
        @(negedge clk);
        bus.we = 1'b0; bus.iss_valid = 1'b0;
        #1;
        ce("zero_rd",       bus.r_data1, 0);
        ce("zero_rd2",      bus.r_data2, 0);
        ce("zero_busy",     bus.busy1,   0);

        // Mid-sweep reset, writes/issues during INIT ignored
        bus.r_addr1 = 4'd3; bus.r_addr2 = 4'd12;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.we = 1'b1; bus.w_addr = 4'd3; bus.w_data = 16'hAAAA;
        bus.iss_valid = 1'b1; bus.iss_addr = 4'd3;
        repeat (9) @(negedge clk);
        #1;
        ce("mid_init_done", bus.init_done, 0);
        ce("mid_init_rd",   bus.r_data1,   0);
        ce("mid_init_busy", bus.busy2,     0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_init("mid_init_len");
        ce("mid_r3_zero",   bus.r_data1, 16'h0000);
        ce("mid_r3_busy",   bus.busy1,   0);
        ce("mid_r12_busy",  bus.busy2,   0);
        bus.r_addr1 = 4'd5; bus.r_addr2 = 4'd7;
        #1;
        ce("mid_r5_zero",   bus.r_data1, 0);
        ce("mid_r7_busy",   bus.busy2,   0);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL queue_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_sb
`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 16, register width in bits.
REQ-002 Parameter DEPTH, default 16, number of registers; power of two, >= 4.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH), address width.
REQ-004 Parameter BYPASS, default 1, 1 = write-to-read forwarding enabled.
REQ-005 Parameter ZERO_REG, default 1, 1 = register 0 reads 0 and ignores writes and issues.
REQ-006 clk  input  1  sole clock, all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 we  input  1  write enable.
REQ-009 w_addr  input  ADDR_W  write address.
REQ-010 w_data  input  DATA_W  write data.
REQ-011 iss_valid  input  1  issue strobe: mark iss_addr as pending a write.
REQ-012 iss_addr  input  ADDR_W  destination register being issued.
REQ-013 r_addr1, r_addr2  input  ADDR_W  read addresses.
REQ-014 r_data1, r_data2  output  DATA_W  combinational read data.
REQ-015 busy1, busy2  output  1  scoreboard pending bit for r_addr1 and r_addr2.
REQ-016 init_done  output  1  high once the clear sequence has completed.

Function
REQ-017 FSM with two states: INIT (clear in progress) and RUN.
- INIT: a counter starting at 0 writes 0 to reg[cnt] and clears busy[cnt] each cycle.
- After cnt = DEPTH-1 is cleared, the next state is RUN.
- INIT lasts exactly DEPTH cycles.
REQ-018 init_done shall be 0 in INIT and 1 in RUN; it is registered.
REQ-019 In INIT the block shall ignore we and iss_valid, and drive r_data* = 0 and busy* = 0.
REQ-020 In RUN, we = 1 shall update reg[w_addr] <= w_data at the clock edge; write latency is 1 cycle.
REQ-021 Reads shall be combinational: r_dataN = reg[r_addrN], with zero-cycle latency.
REQ-022 If BYPASS = 1, we = 1 and r_addrN == w_addr, then r_dataN shall equal w_data in the same cycle. If BYPASS = 0, the read returns the old value.
REQ-023 Scoreboard: iss_valid = 1 shall set busy[iss_addr] at the edge; we = 1 shall clear busy[w_addr] at the edge.
REQ-024 Issue and write to the same address in the same cycle: busy stays set (issue wins), and the data is still written.
REQ-025 busyN = busy[r_addrN], registered state only; no same-cycle bypass of issue or write into busy.
REQ-026 If ZERO_REG = 1:
- r_dataN = 0 and busyN = 0 whenever r_addrN = 0.
- Writes and issues to address 0 are discarded, and the bypass never forwards to address 0.
REQ-027 Writing a register whose busy bit is 0 is legal: data updates and busy remains 0.

Reset
REQ-028 rst = 1 at a clock edge shall:
- enter INIT with cnt = 0 and init_done = 0,
- abandon any in-progress clear sequence, so the full DEPTH-cycle clear restarts.
REQ-029 Register contents are not reset directly; they are zeroed by the INIT sweep.
REQ-030 While rst is held, the block shall remain in INIT at cnt = 0.

Structure
REQ-031 Shared package regfile_pkg shall hold the FSM state enum (RF_INIT, RF_RUN) and the default-width constants.
REQ-032 A single sub-module rf_scoreboard (DEPTH busy bits, set/clear/lookup logic) is natural; the data array and FSM stay in the top.

Verification
REQ-033 Init: pulse rst for 1 cycle -> init_done = 0 for exactly 16 cycles, then 1; all reads return 0x0000.
REQ-034 Write/read: in RUN, write 0xBEEF to r5, then read r_addr1 = 5 next cycle -> 0xBEEF. With BYPASS = 1, reading r5 in the same cycle as writing 0x1234 -> 0x1234; with BYPASS = 0 -> 0xBEEF.
REQ-035 Scoreboard: issue r7 -> busy1 = 1 for r_addr1 = 7 from the next cycle; write r7 = 0x0042 -> busy1 = 0 next cycle and data = 0x0042. Simultaneous issue and write to r7 -> busy stays 1.
REQ-036 Zero register: write 0xFFFF to r0 and issue r0 -> reads of r0 return 0x0000 and busy = 0.
REQ-037 Mid-init reset: assert rst at cnt = 9 -> init restarts and init_done rises 16 cycles after rst deasserts. A write of 0xAAAA to r3 during INIT is ignored -> r3 reads 0x0000 after init.
